stage_id_issue: RTL and testbench

- Parametrised multithreaded decode/issue stage. Sits between IF and EX.
- Takes pre-decoded instructions and tracks pending writes per thread with a register scoreboard.
- Holds back RAW-hazarded instructions, with write-back bypass. Issues into a registered, valid/ready-handshaked IDEX slot.
- Supports per-thread flush.

---
 rtl/common_pkg.sv | 32 +++
 rtl/id_scoreboard.sv | 64 ++++++
 rtl/stage_id_issue.sv | 123 ++++++++++++
 tb/tb_stage_id_issue.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared types and defaults for the ID/issue stage slice.
// Default widths for threads, registers, datapath and the decoded-control payload.
package common;

    localparam int N_THREADS_DEF = 4;
    localparam int N_REGS_DEF    = 32;
    localparam int XLEN_DEF      = 32;

    // Width helper that never returns zero, so a single-thread build still has a 1-bit id.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TID_W_DEF = clog2_min1(N_THREADS_DEF);
    localparam int RID_W_DEF = $clog2(N_REGS_DEF);

    typedef logic [TID_W_DEF-1:0] threadid_t;
    typedef logic [RID_W_DEF-1:0] regid_t;
    typedef logic [XLEN_DEF-1:0]  word_t;
    typedef logic [XLEN_DEF-1:0]  vptr_t;

    // Decoded control bundle; this stage never looks inside it.
    typedef struct packed {
        logic [5:0]  alu_func;
        logic [1:0]  op_a_sel;
        logic [1:0]  op_b_sel;
        logic [21:0] flags;
    } payload_t;

    localparam int PAYLOAD_W_DEF = $bits(payload_t);

endpackage

// File: rtl/id_scoreboard.sv
// Per-thread register scoreboard: one busy bit per (thread, register).
// Register 0 is hardwired zero and never marked busy.
module id_scoreboard
    import common::*;
#(
    parameter int N_THREADS = N_THREADS_DEF,
    parameter int N_REGS    = N_REGS_DEF,
    localparam int TID_W    = clog2_min1(N_THREADS),
    localparam int RID_W    = $clog2(N_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [TID_W-1:0] set_thread,
    input  logic [RID_W-1:0] set_reg,
    input  logic             clr_en,
    input  logic [TID_W-1:0] clr_thread,
    input  logic [RID_W-1:0] clr_reg,
    input  logic             flush_en,
    input  logic [TID_W-1:0] flush_thread,
    input  logic [TID_W-1:0] lk_thread,
    input  logic [RID_W-1:0] lk_reg1,
    input  logic [RID_W-1:0] lk_reg2,
    output logic             busy1,
    output logic             busy2
);

    logic [N_REGS-1:0] busy      [N_THREADS];
    logic [N_REGS-1:0] busy_next [N_THREADS];

    // Next-state: flush wipes a thread's row, write-back clears one bit, issue sets one bit and wins.
    always_comb begin
        busy_next = busy;
        for (int t = 0; t < N_THREADS; t++) begin
            if (flush_en && flush_thread == TID_W'(t)) begin
                busy_next[t] = '0;
            end
        end
        if (clr_en) begin
            busy_next[clr_thread][clr_reg] = 1'b0;
        end
        if (set_en && set_reg != '0) begin
            busy_next[set_thread][set_reg] = 1'b1;
        end
        for (int t = 0; t < N_THREADS; t++) begin
            busy_next[t][0] = 1'b0;
        end
    end

    // Busy flops, cleared by reset.
    always_ff @(posedge clk) begin
        for (int t = 0; t < N_THREADS; t++) begin
            if (rst) begin
                busy[t] <= '0;
            end else begin
                busy[t] <= busy_next[t];
            end
        end
    end

    assign busy1 = busy[lk_thread][lk_reg1];
    assign busy2 = busy[lk_thread][lk_reg2];

endmodule

// File: rtl/stage_id_issue.sv
// Multithreaded decode/issue stage between IF and EX.
// Stalls RAW hazards using id_scoreboard and issues into a registered valid/ready IDEX slot.
// Optional macro ID_WB_BYPASS_EN: same-cycle write-back resolves a hazard and forwards wb_data.
// Without it the reader waits until the cycle after the write-back and reads the regfile.
module stage_id_issue
    import common::*;
#(
    parameter int N_THREADS = N_THREADS_DEF,
    parameter int N_REGS    = N_REGS_DEF,
    parameter int XLEN      = XLEN_DEF,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    localparam int TID_W    = clog2_min1(N_THREADS),
    localparam int RID_W    = $clog2(N_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    output logic                 if_ready,
    input  logic [TID_W-1:0]     if_thread,
    input  logic [XLEN-1:0]      if_pc,
    input  logic [RID_W-1:0]     if_rs1,
    input  logic [RID_W-1:0]     if_rs2,
    input  logic                 if_use_rs1,
    input  logic                 if_use_rs2,
    input  logic [RID_W-1:0]     if_rd,
    input  logic                 if_rd_we,
    input  logic [PAYLOAD_W-1:0] if_payload,
    output logic [TID_W-1:0]     rf_thread,
    output logic [RID_W-1:0]     rf_raddr1,
    output logic [RID_W-1:0]     rf_raddr2,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    input  logic                 wb_valid,
    input  logic [TID_W-1:0]     wb_thread,
    input  logic [RID_W-1:0]     wb_dst,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush_en,
    input  logic [TID_W-1:0]     flush_thread,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [TID_W-1:0]     ex_thread,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_r1,
    output logic [XLEN-1:0]      ex_r2,
    output logic [RID_W-1:0]     ex_dst,
    output logic                 ex_rd_we,
    output logic [PAYLOAD_W-1:0] ex_payload
);

    logic busy1;
    logic busy2;
    logic byp1;
    logic byp2;
    logic hazard;
    logic slot_free;
    logic issue;

    assign rf_thread = if_thread;
    assign rf_raddr1 = if_rs1;
    assign rf_raddr2 = if_rs2;

`ifdef ID_WB_BYPASS_EN
    assign byp1 = wb_valid && (wb_thread == if_thread) && (wb_dst == if_rs1) && (if_rs1 != '0);
    assign byp2 = wb_valid && (wb_thread == if_thread) && (wb_dst == if_rs2) && (if_rs2 != '0);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign hazard    = (if_use_rs1 && busy1 && !byp1) || (if_use_rs2 && busy2 && !byp2);
    assign slot_free = !ex_valid || ex_ready;
    assign if_ready  = slot_free && !hazard;
    assign issue     = if_valid && if_ready && !(flush_en && flush_thread == if_thread);

    id_scoreboard #(
        .N_THREADS (N_THREADS),
        .N_REGS    (N_REGS)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .set_en       (issue && if_rd_we),
        .set_thread   (if_thread),
        .set_reg      (if_rd),
        .clr_en       (wb_valid),
        .clr_thread   (wb_thread),
        .clr_reg      (wb_dst),
        .flush_en     (flush_en),
        .flush_thread (flush_thread),
        .lk_thread    (if_thread),
        .lk_reg1      (if_rs1),
        .lk_reg2      (if_rs2),
        .busy1        (busy1),
        .busy2        (busy2)
    );

    // IDEX slot: load on issue, otherwise drain when consumed, or drop a stalled slot of a flushed thread.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_thread  <= '0;
            ex_pc      <= '0;
            ex_r1      <= '0;
            ex_r2      <= '0;
            ex_dst     <= '0;
            ex_rd_we   <= 1'b0;
            ex_payload <= '0;
        end else if (issue) begin
            ex_valid   <= 1'b1;
            ex_thread  <= if_thread;
            ex_pc      <= if_pc;
            ex_r1      <= byp1 ? wb_data : rf_rdata1;
            ex_r2      <= byp2 ? wb_data : rf_rdata2;
            ex_dst     <= if_rd;
            ex_rd_we   <= if_rd_we;
            ex_payload <= if_payload;
        end else if (ex_ready) begin
            ex_valid   <= 1'b0;
        end else if (flush_en && ex_valid && ex_thread == flush_thread) begin
            ex_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_id_issue.sv
// Directed, table-driven bench for stage_id_issue with hand-computed expectations.
// Expectations adapt to whether ID_WB_BYPASS_EN is defined.
module tb_stage_id_issue;

    localparam logic [31:0] PKEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_ready;
    logic [1:0]  if_thread;
    logic [31:0] if_pc;
    logic [4:0]  if_rs1, if_rs2, if_rd;
    logic        if_use_rs1, if_use_rs2, if_rd_we;
    logic [31:0] if_payload;
    logic [1:0]  rf_thread;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_valid;
    logic [1:0]  wb_thread;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        flush_en;
    logic [1:0]  flush_thread;
    logic        ex_valid, ex_ready;
    logic [1:0]  ex_thread;
    logic [31:0] ex_pc, ex_r1, ex_r2;
    logic [4:0]  ex_dst;
    logic        ex_rd_we;
    logic [31:0] ex_payload;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [31:0] v, th, pc, rs1, u1, rs2, u2, rd, we;
        logic [31:0] wbv, wbt, wbd, wbdat, fl, flt, exr;
        logic [31:0] e_rdy, e_val, e_th, e_pc, e_r1, e_r2, e_dst, e_we;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    // Regfile model: value encodes thread and register.
    function automatic logic [31:0] rf(input logic [1:0] t, input logic [4:0] r);
        return 32'hA000_0000 | (32'(t) << 8) | 32'(r);
    endfunction

    assign rf_rdata1 = rf(rf_thread, rf_raddr1);
    assign rf_rdata2 = rf(rf_thread, rf_raddr2);

    stage_id_issue dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_thread(if_thread), .if_pc(if_pc),
        .if_rs1(if_rs1), .if_rs2(if_rs2), .if_use_rs1(if_use_rs1), .if_use_rs2(if_use_rs2),
        .if_rd(if_rd), .if_rd_we(if_rd_we), .if_payload(if_payload),
        .rf_thread(rf_thread), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_valid(wb_valid), .wb_thread(wb_thread), .wb_dst(wb_dst), .wb_data(wb_data),
        .flush_en(flush_en), .flush_thread(flush_thread),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_thread(ex_thread), .ex_pc(ex_pc),
        .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_dst(ex_dst), .ex_rd_we(ex_rd_we),
        .ex_payload(ex_payload)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_inputs(input vec_t x);
        if_valid     = x.v[0];
        if_thread    = x.th[1:0];
        if_pc        = x.pc;
        if_rs1       = x.rs1[4:0];
        if_use_rs1   = x.u1[0];
        if_rs2       = x.rs2[4:0];
        if_use_rs2   = x.u2[0];
        if_rd        = x.rd[4:0];
        if_rd_we     = x.we[0];
        if_payload   = x.pc ^ PKEY;
        wb_valid     = x.wbv[0];
        wb_thread    = x.wbt[1:0];
        wb_dst       = x.wbd[4:0];
        wb_data      = x.wbdat;
        flush_en     = x.fl[0];
        flush_thread = x.flt[1:0];
        ex_ready     = x.exr[0];
    endtask

    task automatic apply_stimulus(input vec_t x, input string tag);
        drive_inputs(x);
        #1;
        check_output({tag, " if_ready"}, 32'(if_ready), x.e_rdy);
        @(posedge clk);
        #1;
        check_output({tag, " ex_valid"}, 32'(ex_valid), x.e_val);
        if (x.e_val[0]) begin
            check_output({tag, " ex_thread"}, 32'(ex_thread), x.e_th);
            check_output({tag, " ex_pc"}, ex_pc, x.e_pc);
            check_output({tag, " ex_r1"}, ex_r1, x.e_r1);
            check_output({tag, " ex_r2"}, ex_r2, x.e_r2);
            check_output({tag, " ex_dst"}, 32'(ex_dst), x.e_dst);
            check_output({tag, " ex_rd_we"}, 32'(ex_rd_we), x.e_we);
            check_output({tag, " ex_payload"}, ex_payload, x.e_pc ^ PKEY);
        end
    endtask

    initial begin
        vec_t h;

        // Thread 0 RAW on r5 with write-back.
        vecs.push_back('{1,0,'h100,1,1,2,1,5,1, 0,0,0,0,0,0,1, 1,1,0,'h100,'hA0000001,'hA0000002,5,1});
        vecs.push_back('{1,0,'h104,5,1,0,0,6,1, 0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0});
`ifdef ID_WB_BYPASS_EN
        vecs.push_back('{1,0,'h104,5,1,0,0,6,1, 1,0,5,'hDEAD0005,0,0,1, 1,1,0,'h104,'hDEAD0005,'hA0000000,6,1});
`else
        vecs.push_back('{1,0,'h104,5,1,0,0,6,1, 1,0,5,'hDEAD0005,0,0,1, 0,0,0,0,0,0,0,0});
`endif
        vecs.push_back('{1,0,'h104,5,1,0,0,6,1, 0,0,0,0,0,0,1, 1,1,0,'h104,'hA0000005,'hA0000000,6,1});
        // Other thread is independent; r0 writes never mark busy.
        vecs.push_back('{1,1,'h200,6,1,0,0,0,0, 0,0,0,0,0,0,1, 1,1,1,'h200,'hA0000106,'hA0000100,0,0});
        vecs.push_back('{1,1,'h204,0,1,0,1,0,1, 0,0,0,0,0,0,1, 1,1,1,'h204,'hA0000100,'hA0000100,0,1});
        vecs.push_back('{1,1,'h208,0,1,0,1,7,1, 0,0,0,0,0,0,1, 1,1,1,'h208,'hA0000100,'hA0000100,7,1});
        vecs.push_back('{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1, 1,0,0,0,0,0,0,0});
        // Same-cycle clear and set of t0 r4: set wins.
        vecs.push_back('{1,0,'h300,1,0,2,0,4,1, 1,0,4,'h44444444,0,0,1, 1,1,0,'h300,'hA0000001,'hA0000002,4,1});
        vecs.push_back('{1,0,'h304,4,1,0,0,0,0, 0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0});
`ifdef ID_WB_BYPASS_EN
        vecs.push_back('{1,0,'h304,4,1,0,0,0,0, 1,0,4,'hBEEF0004,0,0,1, 1,1,0,'h304,'hBEEF0004,'hA0000000,0,0});
`else
        vecs.push_back('{1,0,'h304,4,1,0,0,0,0, 1,0,4,'hBEEF0004,0,0,1, 0,0,0,0,0,0,0,0});
`endif
        vecs.push_back('{1,0,'h304,4,1,0,0,0,0, 0,0,0,0,0,0,1, 1,1,0,'h304,'hA0000004,'hA0000000,0,0});
        // rs2 hazard on t1 r7.
        vecs.push_back('{1,1,'h400,3,0,7,1,0,0, 0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0});
`ifdef ID_WB_BYPASS_EN
        vecs.push_back('{1,1,'h400,3,0,7,1,0,0, 1,1,7,'h77777777,0,0,1, 1,1,1,'h400,'hA0000103,'h77777777,0,0});
`else
        vecs.push_back('{1,1,'h400,3,0,7,1,0,0, 1,1,7,'h77777777,0,0,1, 0,0,0,0,0,0,0,0});
`endif
        vecs.push_back('{1,1,'h400,3,0,7,1,0,0, 0,0,0,0,0,0,1, 1,1,1,'h400,'hA0000103,'hA0000107,0,0});
        // Flush suppresses the IF instruction of the flushed thread.
        vecs.push_back('{1,2,'h500,0,0,0,0,3,1, 0,0,0,0,1,2,1, 1,0,0,0,0,0,0,0});
        vecs.push_back('{1,2,'h504,3,1,0,0,0,0, 0,0,0,0,0,0,1, 1,1,2,'h504,'hA0000203,'hA0000200,0,0});
        // Backpressure hold for three cycles, then back-to-back issue.
        vecs.push_back('{1,3,'h600,1,1,0,0,9,1, 0,0,0,0,0,0,1, 1,1,3,'h600,'hA0000301,'hA0000300,9,1});
        for (int k = 0; k < 3; k++) begin
            vecs.push_back('{1,3,'h604,2,1,0,0,10,1, 0,0,0,0,0,0,0, 0,1,3,'h600,'hA0000301,'hA0000300,9,1});
        end
        vecs.push_back('{1,3,'h604,2,1,0,0,10,1, 0,0,0,0,0,0,1, 1,1,3,'h604,'hA0000302,'hA0000300,10,1});
        vecs.push_back('{1,3,'h608,1,1,0,0,0,0, 0,0,0,0,0,0,1, 1,1,3,'h608,'hA0000301,'hA0000300,0,0});
        // Thread 2 marks r3 and r7 busy and leaves its instruction stalled in the slot.
        vecs.push_back('{1,2,'h700,0,0,0,0,3,1, 0,0,0,0,0,0,1, 1,1,2,'h700,'hA0000200,'hA0000200,3,1});
        vecs.push_back('{1,2,'h704,0,0,0,0,7,1, 0,0,0,0,0,0,1, 1,1,2,'h704,'hA0000200,'hA0000200,7,1});
        vecs.push_back('{0,2,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,1,2,'h704,'hA0000200,'hA0000200,7,1});

        // Reset with idle inputs.
        drive_inputs('{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0});
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset ex_valid", 32'(ex_valid), 32'd0);
        check_output("reset ex_pc", ex_pc, 32'd0);
        check_output("reset ex_r1", ex_r1, 32'd0);
        check_output("reset ex_payload", ex_payload, 32'd0);
        check_output("reset if_ready", 32'(if_ready), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i], $sformatf("v%0d", i));
        end

        // Flush t2 while its instruction is stalled in the slot.
        h = '{1,2,'h708,3,1,7,1,0,0, 0,0,0,0,1,2,0, 0,0,0,0,0,0,0,0};
        drive_inputs(h);
        #1;
        check_output("flush if_ready", 32'(if_ready), 32'd0);
        @(posedge clk);
        #1;
        check_output("flush ex_valid", 32'(ex_valid), 32'd0);
        h = '{1,3,'h800,9,1,0,0,0,0, 0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0};
        drive_inputs(h);
        #1;
        check_output("flush t3 kept busy", 32'(if_ready), 32'd0);
        h = '{1,2,'h708,3,1,7,1,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
        drive_inputs(h);
        #1;
        check_output("flush t2 freed", 32'(if_ready), 32'd1);
        @(posedge clk);
        #1;
        check_output("post-flush ex_valid", 32'(ex_valid), 32'd1);
        check_output("post-flush ex_r1", ex_r1, 32'hA0000203);
        check_output("post-flush ex_r2", ex_r2, 32'hA0000207);

        // Reset mid-operation drops the slot and clears the scoreboard.
        if_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check_output("midrst ex_valid", 32'(ex_valid), 32'd0);
        check_output("midrst ex_pc", ex_pc, 32'd0);
        rst = 1'b0;
        h = '{1,3,'h900,9,1,10,1,0,0, 0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0};
        drive_inputs(h);
        #1;
        check_output("midrst scoreboard clear", 32'(if_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
